// File: rtl/rysy_dmem_if.sv
// Load/store bus between rysy_core (master) and its data memory (slave).
interface rysy_dmem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic                  req;
  logic                  we;
  logic [BYTES-1:0]      be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  err;

  modport master (
    output req, we, be, addr, wdata,
    input  rdata, ready, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output rdata, ready, err
  );
endinterface

// File: rtl/rysy_dmem_ctrl.sv
// Data-memory controller for the rysy_core load/store port: accepts one
// request at a time, waits LATENCY cycles, then commits the write or returns
// the read word together with a one-cycle ready pulse and a fault flag.
module rysy_dmem_ctrl #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter int                    LATENCY     = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic       clk,
  input  logic       rst,
  rysy_dmem_if.slave bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // Byte span of the array, one bit wider than an address so it cannot wrap.
  localparam logic [ADDR_WIDTH:0]   SPAN       = (ADDR_WIDTH+1)'(DEPTH_WORDS * BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [2:0]            CNT_INIT   = 3'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("rysy_dmem_ctrl: LATENCY must be in 1..4");
  end
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("rysy_dmem_ctrl: DATA_WIDTH must be a nonzero multiple of 8");
  end
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("rysy_dmem_ctrl: DEPTH_WORDS must be a power of 2, at least 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [2:0]            cnt;
  logic                  we_q;
  logic [BYTES-1:0]      be_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Decode of the latched request address.
  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic                  misaligned;
  logic                  fault;
  logic [IDX_W-1:0]      index;
  logic                  mem_wr;

  assign offset     = addr_q - BASE_ADDR;
  assign in_range   = (addr_q >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign misaligned = |(addr_q & ALIGN_MASK);
  assign fault      = misaligned || !in_range;
  assign index      = IDX_W'(offset >> OFF_W);
  assign mem_wr     = (state == RESP) && we_q && !fault;

  // State register; reset abandons any access in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic: IDLE accepts, WAIT counts down, RESP lasts one cycle.
  // NOTE: the default assignment first keeps this block free of inferred
  // latches on paths that do not mention state_next.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req) state_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 3'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, wait counter and registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bus.rdata <= '0;
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
    end else begin
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            be_q    <= bus.be;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            cnt     <= CNT_INIT;
          end
        end
        WAIT: cnt <= cnt - 3'd1;
        RESP: begin
          bus.ready <= 1'b1;
          bus.err   <= fault;
          // A faulted access always returns zero data; a good write leaves
          // the last read word in place.
          if (fault)      bus.rdata <= '0;
          else if (!we_q) bus.rdata <= mem[index];
        end
        default: ;
      endcase
    end
  end

  // Byte-merged write into the storage array.
  // NOTE: the array has no reset; clearing it would need a multi-cycle sweep
  // and its contents are allowed to survive a controller reset.
  always_ff @(posedge clk) begin
    if (rst && mem_wr) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be_q[i]) mem[index][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_rysy_dmem_ctrl.sv
// Directed bench for rysy_dmem_ctrl: one instance at LATENCY=1 and one at
// LATENCY=3 share a single stimulus bus, selected by sel.
module tb_rysy_dmem_ctrl;

  logic clk = 1'b0;
  logic rst1, rst3;
  always #5 clk = ~clk;

  rysy_dmem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if1 ();
  rysy_dmem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if3 ();

  rysy_dmem_ctrl #(.LATENCY(1)) u_l1 (.clk(clk), .rst(rst1), .bus(if1));
  rysy_dmem_ctrl #(.LATENCY(3)) u_l3 (.clk(clk), .rst(rst3), .bus(if3));

  // Shared stimulus, steered to one DUT.
  logic        sel;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;

  assign if1.req = req & ~sel;
  assign if3.req = req & sel;
  assign if1.we = we;    assign if3.we = we;
  assign if1.be = be;    assign if3.be = be;
  assign if1.addr = addr;   assign if3.addr = addr;
  assign if1.wdata = wdata; assign if3.wdata = wdata;

  logic        cur_ready, cur_err;
  logic [31:0] cur_rdata;
  assign cur_ready = sel ? if3.ready : if1.ready;
  assign cur_err   = sel ? if3.err   : if1.err;
  assign cur_rdata = sel ? if3.rdata : if1.rdata;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access: request accepted at the next edge, then wait (bounded) for
  // ready and check its latency and err. Returns the sampled rdata.
  task automatic do_access(input string tag, input logic w, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] d, input int lat,
                           input logic exp_err, output logic [31:0] rd);
    int  cycles;
    logic seen;
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    tick();
    req = 1'b0;
    cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!seen) begin
        tick();
        cycles++;
        if (cur_ready) seen = 1'b1;
      end
    end
    check({tag, "/latency"}, 32'(cycles), 32'(lat));
    check({tag, "/err"}, {31'd0, cur_err}, {31'd0, exp_err});
    rd = cur_rdata;
  endtask

  logic [31:0] rd;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    rst1 = 1'b0; rst3 = 1'b0;
    tick(); tick();
    check("reset/l1_ready", {31'd0, if1.ready}, 32'd0);
    check("reset/l1_err",   {31'd0, if1.err},   32'd0);
    check("reset/l1_rdata", if1.rdata,          32'd0);
    check("reset/l3_ready", {31'd0, if3.ready}, 32'd0);
    check("reset/l3_rdata", if3.rdata,          32'd0);
    rst1 = 1'b1; rst3 = 1'b1;
    tick();

    // 1: full write then read at LATENCY=1; ready is a single-cycle pulse.
    do_access("t1_wr", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1, 1'b0, rd);
    check("t1_wr/rdata_kept", rd, 32'd0);
    tick();
    check("t1/pulse_one_cycle", {31'd0, cur_ready}, 32'd0);
    do_access("t1_rd", 1'b0, 32'h10, 4'h0, 32'h0, 1, 1'b0, rd);
    check("t1_rd/rdata", rd, 32'hDEADBEEF);

    // 2: partial byte-enable merge; write responses leave rdata alone.
    do_access("t2_wr0", 1'b1, 32'h20, 4'hF, 32'h11223344, 1, 1'b0, rd);
    do_access("t2_wr1", 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 1, 1'b0, rd);
    check("t2_wr1/rdata_kept", rd, 32'hDEADBEEF);
    do_access("t2_rd", 1'b0, 32'h20, 4'hF, 32'h0, 1, 1'b0, rd);
    check("t2_rd/rdata", rd, 32'h11BB33DD);

    // 4: faults -- misaligned write, out-of-range read, both at once.
    do_access("t4_misal", 1'b1, 32'h22, 4'hF, 32'hFFFFFFFF, 1, 1'b1, rd);
    do_access("t4_oor", 1'b0, 32'h1000, 4'hF, 32'h0, 1, 1'b1, rd);
    check("t4_oor/rdata", rd, 32'd0);
    do_access("t4_both", 1'b1, 32'h1001, 4'hF, 32'h0, 1, 1'b1, rd);
    do_access("t4_rd20", 1'b0, 32'h20, 4'hF, 32'h0, 1, 1'b0, rd);
    check("t4_rd20/rdata", rd, 32'h11BB33DD);
    do_access("t4_lastwr", 1'b1, 32'hFFC, 4'hF, 32'h0BADC0DE, 1, 1'b0, rd);
    do_access("t4_lastrd", 1'b0, 32'hFFC, 4'hF, 32'h0, 1, 1'b0, rd);
    check("t4_lastrd/rdata", rd, 32'h0BADC0DE);

    // 6: be=0 write is a legal no-op.
    do_access("t6_wr", 1'b1, 32'h40, 4'hF, 32'h55AA55AA, 1, 1'b0, rd);
    do_access("t6_be0", 1'b1, 32'h40, 4'h0, 32'hFFFFFFFF, 1, 1'b0, rd);
    do_access("t6_rd", 1'b0, 32'h40, 4'hF, 32'h0, 1, 1'b0, rd);
    check("t6_rd/rdata", rd, 32'h55AA55AA);

    // 3: LATENCY=3 with req held high: responses at E0+3 and E0+7 only.
    sel = 1'b1;
    do_access("t3_wr", 1'b1, 32'h04, 4'hF, 32'h01020304, 3, 1'b0, rd);
    req = 1'b1; we = 1'b0; addr = 32'h04; be = 4'hF;
    tick();                                   // E0
    tick(); check("t3/e1_ready", {31'd0, cur_ready}, 32'd0);
    tick(); check("t3/e2_ready", {31'd0, cur_ready}, 32'd0);
    tick(); check("t3/e3_ready", {31'd0, cur_ready}, 32'd1);
    check("t3/e3_rdata", cur_rdata, 32'h01020304);
    tick(); check("t3/e4_ready", {31'd0, cur_ready}, 32'd0);
    req = 1'b0;
    tick(); check("t3/e5_ready", {31'd0, cur_ready}, 32'd0);
    tick(); check("t3/e6_ready", {31'd0, cur_ready}, 32'd0);
    tick(); check("t3/e7_ready", {31'd0, cur_ready}, 32'd1);
    tick();

    // 5: reset at E0+2 of a LATENCY=3 write abandons it.
    do_access("t5_pre", 1'b1, 32'h30, 4'hF, 32'h12345678, 3, 1'b0, rd);
    req = 1'b1; we = 1'b1; addr = 32'h30; be = 4'hF; wdata = 32'hCAFEF00D;
    tick();                                   // E0
    req = 1'b0;
    tick();                                   // E0+1
    rst3 = 1'b0;
    tick();                                   // E0+2, reset sampled
    check("t5/rst_ready", {31'd0, cur_ready}, 32'd0);
    check("t5/rst_rdata", cur_rdata, 32'd0);
    rst3 = 1'b1;
    tick(); check("t5/e3_ready", {31'd0, cur_ready}, 32'd0);
    tick(); check("t5/e4_ready", {31'd0, cur_ready}, 32'd0);
    do_access("t5_rd", 1'b0, 32'h30, 4'hF, 32'h0, 3, 1'b0, rd);
    check("t5_rd/rdata", rd, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
